// File: rtl/fetch_stage_pkg.sv
// Shared fetch-control definitions: fetch FSM states and the default reset PC.
package HighLevelControl;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetchState;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding {PC, Instr} pairs between instruction memory and decode.
module fetch_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pop only a real entry; push when there is room or the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    push_ok = push && ((count != 2'd2) || pop_ok);
  end

  // Pointer and occupancy bookkeeping; clear empties the buffer immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// tracking, redirect flush with drop counting, and a 2-entry decode buffer.
module fetch_stage
  import HighLevelControl::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 IMemReq,
  output logic [WORD_SIZE-1:0] IMemAddr,
  input  logic                 IMemGrant,
  input  logic                 IMemRspValid,
  input  logic [WORD_SIZE-1:0] IMemRspData,
  input  logic                 RedirectEn,
  input  logic [WORD_SIZE-1:0] RedirectPC,
  input  logic                 DecodeReady,
  output logic                 FetchValid,
  output logic [WORD_SIZE-1:0] Instr,
  output logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] PCp4,
  output logic                 FetchMisaligned
);

  fetchState              state;
  fetchState              state_next;
  logic [WORD_SIZE-1:0]   fetch_pc;
  logic [WORD_SIZE-1:0]   fetch_pc_next;
  logic [1:0]             outstanding;
  logic [1:0]             outstanding_next;
  logic [1:0]             out_after_rsp;
  logic [1:0]             drop_cnt;
  logic [1:0]             drop_next;
  logic [2:0]             inflight;
  logic                   req;
  logic                   grant;
  logic                   rsp_counted;
  logic                   rsp_keep;
  logic                   misaligned;

  // Address queue: addresses of granted requests awaiting their responses.
  logic [WORD_SIZE-1:0]   aq_mem [2];
  logic                   aq_rd;
  logic                   aq_wr;
  logic [1:0]             aq_cnt;

  // Decode buffer interface.
  logic [2*WORD_SIZE-1:0] buf_din;
  logic [2*WORD_SIZE-1:0] buf_dout;
  logic                   buf_empty;
  logic [1:0]             buf_count;
  logic                   buf_pop;

  // Request credit and response classification for this cycle.
  always_comb begin
    inflight      = {1'b0, outstanding} + {1'b0, buf_count};
    req           = (state == FETCH) && (inflight < 3'd2) && !RedirectEn;
    grant         = req && IMemGrant;
    rsp_counted   = IMemRspValid && (outstanding != 2'd0);
    rsp_keep      = rsp_counted && (state == FETCH) && !RedirectEn && (aq_cnt != 2'd0);
    out_after_rsp = outstanding - {1'b0, rsp_counted};
  end

  // Next-state, fetch PC and drop-count computation; redirect overrides everything.
  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    drop_next        = drop_cnt;
    outstanding_next = out_after_rsp + {1'b0, grant};
    if (RedirectEn) begin
      fetch_pc_next = {RedirectPC[WORD_SIZE-1:2], 2'b00};
      drop_next     = out_after_rsp;
      state_next    = (out_after_rsp != 2'd0) ? FLUSH : FETCH;
    end else begin
      if (grant) fetch_pc_next = fetch_pc + WORD_SIZE'(4);
      unique case (state)
        IDLE:  state_next = FETCH;
        FETCH: state_next = FETCH;
        FLUSH: begin
          if (rsp_counted) begin
            drop_next = drop_cnt - 2'd1;
            if (drop_cnt == 2'd1) state_next = FETCH;
          end else if (drop_cnt == 2'd0) begin
            state_next = FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control state register: FSM, fetch PC and the two credit counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
    end
  end

  // Address queue pointers: push on grant, pop on each kept response, clear on redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aq_rd  <= 1'b0;
      aq_wr  <= 1'b0;
      aq_cnt <= 2'd0;
    end else if (RedirectEn) begin
      aq_rd  <= 1'b0;
      aq_wr  <= 1'b0;
      aq_cnt <= 2'd0;
    end else begin
      if (grant)    aq_wr <= ~aq_wr;
      if (rsp_keep) aq_rd <= ~aq_rd;
      case ({grant, rsp_keep})
        2'b10:   aq_cnt <= aq_cnt + 2'd1;
        2'b01:   aq_cnt <= aq_cnt - 2'd1;
        default: aq_cnt <= aq_cnt;
      endcase
    end
  end

  // Address queue storage; the granted address is the current fetch PC.
  always_ff @(posedge clk) begin
    if (grant) aq_mem[aq_wr] <= fetch_pc;
  end

  // One-cycle flag for a redirect target that is not word aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misaligned <= 1'b0;
    else          misaligned <= RedirectEn && (RedirectPC[1:0] != 2'b00);
  end

  assign buf_din = {aq_mem[aq_rd], IMemRspData};
  assign buf_pop = FetchValid && DecodeReady;

  fetch_buffer #(
    .WIDTH(2 * WORD_SIZE)
  ) u_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (RedirectEn),
    .push   (rsp_keep),
    .pop    (buf_pop),
    .din    (buf_din),
    .dout   (buf_dout),
    .empty  (buf_empty),
    .count  (buf_count)
  );

  assign IMemReq         = req;
  assign IMemAddr        = fetch_pc;
  assign FetchValid      = !buf_empty && !RedirectEn;
  assign Instr           = buf_dout[WORD_SIZE-1:0];
  assign PC              = buf_dout[2*WORD_SIZE-1:WORD_SIZE];
  assign PCp4            = PC + WORD_SIZE'(4);
  assign FetchMisaligned = misaligned;

  // A response with nothing outstanding outside FLUSH breaks the memory protocol.
  a_rsp_protocol: assert property (@(posedge clk) disable iff (!reset_n)
    !(IMemRspValid && (outstanding == 2'd0) && (state != FLUSH)));

endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage: memory responder, expected-stream scoreboard.
module tb_fetch_stage;
  import HighLevelControl::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGrant = 1'b1;
  logic        IMemRspValid = 1'b0;
  logic [31:0] IMemRspData = 32'h0;
  logic        RedirectEn = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        DecodeReady = 1'b1;
  logic        FetchValid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCp4;
  logic        FetchMisaligned;

  always #5 clk = ~clk;

  fetch_stage #(.WORD_SIZE(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemGrant(IMemGrant), .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .RedirectEn(RedirectEn), .RedirectPC(RedirectPC), .DecodeReady(DecodeReady),
    .FetchValid(FetchValid), .Instr(Instr), .PC(PC), .PCp4(PCp4),
    .FetchMisaligned(FetchMisaligned)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  exp_t        exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_rdy_q[$];
  int          arrived = 0;
  int          cyc = 0;
  int          lat = 1;
  int          mem_mode = 0;
  bit          grant_en = 1'b1;
  bit          dec_rdy = 1'b1;
  int          bench_out = 0;
  int          bench_drop = 0;
  int          since_rst = 0;
  logic [31:0] exp_pc = 32'h0;
  bit          prev_mis = 1'b0;
  bit          hold_valid = 1'b0;
  logic [31:0] hold_pc, hold_instr;
  int          first_grant = -1;
  int          first_valid = -1;
  bit          track_first = 1'b0;
  logic [31:0] first_xfer_pc = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (mem_mode == 0) ? 32'h0000_0013 : {~a[15:0], a[15:0]};
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit          rsp;
    bit          exp_req;
    bit          exp_fv;
    logic [31:0] raddr;
    exp_t        e;
    rsp = 1'b0;
    if (mem_rdy_q.size() > 0) if (mem_rdy_q[0] <= cyc) rsp = 1'b1;
    if (rsp) begin
      raddr = mem_addr_q.pop_front();
      void'(mem_rdy_q.pop_front());
      IMemRspValid = 1'b1;
      IMemRspData  = mem_data(raddr);
    end else begin
      IMemRspValid = 1'b0;
      IMemRspData  = 32'hDEAD_BEEF;
    end
    RedirectEn  = redir;
    RedirectPC  = rpc;
    DecodeReady = dec_rdy;
    IMemGrant   = grant_en;
    #1;
    exp_req = (since_rst >= 1) && (bench_drop == 0) && !redir && (exp_q.size() < 2);
    tests_run++;
    if (IMemReq !== exp_req) begin
      tests_failed++;
      $display("FAIL imemreq cyc=%0d: got %b expected %b", cyc, IMemReq, exp_req);
    end
    exp_fv = (arrived > 0) && !redir;
    tests_run++;
    if (FetchValid !== exp_fv) begin
      tests_failed++;
      $display("FAIL fetchvalid cyc=%0d: got %b expected %b", cyc, FetchValid, exp_fv);
    end
    tests_run++;
    if (FetchMisaligned !== prev_mis) begin
      tests_failed++;
      $display("FAIL misaligned cyc=%0d: got %b expected %b", cyc, FetchMisaligned, prev_mis);
    end
    if (hold_valid && FetchValid) begin
      tests_run++;
      if (PC !== hold_pc || Instr !== hold_instr) begin
        tests_failed++;
        $display("FAIL stall_hold cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 cyc, PC, Instr, hold_pc, hold_instr);
      end
    end
    if (FetchValid === 1'b1 && first_valid < 0) first_valid = since_rst;
    if (IMemReq === 1'b1 && IMemGrant) begin
      tests_run++;
      if (IMemAddr !== exp_pc) begin
        tests_failed++;
        $display("FAIL imemaddr cyc=%0d: got %h expected %h", cyc, IMemAddr, exp_pc);
      end
      if (first_grant < 0) first_grant = since_rst;
      mem_addr_q.push_back(IMemAddr);
      mem_rdy_q.push_back(cyc + lat);
      exp_q.push_back('{pc: exp_pc, instr: mem_data(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      bench_out++;
    end
    if (FetchValid === 1'b1 && DecodeReady) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL xfer_unexpected cyc=%0d: got pc=%h expected no transfer", cyc, PC);
      end else begin
        e = exp_q.pop_front();
        if (arrived > 0) arrived--;
        if (PC !== e.pc || Instr !== e.instr || PCp4 !== e.pc + 32'd4) begin
          tests_failed++;
          $display("FAIL xfer cyc=%0d: got pc=%h instr=%h pcp4=%h expected pc=%h instr=%h pcp4=%h",
                   cyc, PC, Instr, PCp4, e.pc, e.instr, e.pc + 32'd4);
        end
        if (track_first) begin
          first_xfer_pc = PC;
          track_first   = 1'b0;
        end
      end
    end
    hold_valid = (FetchValid === 1'b1) && !DecodeReady;
    hold_pc    = PC;
    hold_instr = Instr;
    if (rsp) begin
      bench_out--;
      if (!redir && bench_drop == 0) arrived++;
      else if (!redir && bench_drop > 0) bench_drop--;
    end
    if (redir) begin
      exp_q.delete();
      arrived    = 0;
      exp_pc     = {rpc[31:2], 2'b00};
      bench_drop = bench_out;
      hold_valid = 1'b0;
    end
    prev_mis = redir && (rpc[1:0] != 2'b00);
    since_rst++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Hold reset for ncyc edges, checking the reset output values, then release.
  task automatic apply_reset(input int ncyc);
    reset_n = 1'b0;
    RedirectEn = 1'b0; IMemRspValid = 1'b0; DecodeReady = 1'b1; IMemGrant = 1'b1;
    exp_q.delete(); mem_addr_q.delete(); mem_rdy_q.delete();
    arrived = 0; bench_out = 0; bench_drop = 0; prev_mis = 1'b0; hold_valid = 1'b0;
    exp_pc = 32'h0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (IMemReq !== 1'b0 || FetchValid !== 1'b0 || FetchMisaligned !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got req=%b fv=%b mis=%b expected 0 0 0",
                 IMemReq, FetchValid, FetchMisaligned);
      end
      @(negedge clk);
      cyc++;
    end
    reset_n = 1'b1;
    since_rst = 0; first_grant = -1; first_valid = -1;
  endtask

  // Stop issuing and let every outstanding and buffered entry drain to decode.
  task automatic drain(input string name);
    grant_en = 1'b0;
    dec_rdy  = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || bench_out > 0); i++) step(1'b0, 32'h0);
    tests_run++;
    if (exp_q.size() != 0 || bench_out != 0) begin
      tests_failed++;
      $display("FAIL drain_%s: got %0d entries left expected 0", name, exp_q.size() + bench_out);
    end
    grant_en = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    drain("reset");
  endtask

  task automatic test_stream();
    mem_mode = 0;
    lat = 1;
    apply_reset(2);
    for (int i = 0; i < 14; i++) step(1'b0, 32'h0);
    tests_run++;
    if (first_grant != 1 || first_valid != 3) begin
      tests_failed++;
      $display("FAIL latency: got grant@%0d valid@%0d expected grant@1 valid@3",
               first_grant, first_valid);
    end
    drain("stream");
  endtask

  task automatic test_stall();
    mem_mode = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
    dec_rdy = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
    tests_run++;
    if (IMemReq !== 1'b0 || FetchValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_state: got req=%b fv=%b expected req=0 fv=1", IMemReq, FetchValid);
    end
    dec_rdy = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
    drain("stall");
  endtask

  task automatic test_redirect_flush();
    bit found;
    mem_mode = 1;
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bench_out == 2 && !(mem_rdy_q.size() > 0 && mem_rdy_q[0] <= cyc)) found = 1'b1;
      else step(1'b0, 32'h0);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL flush_setup: got outstanding=%0d expected 2", bench_out);
    end
    step(1'b1, 32'h0000_0100);
    track_first = 1'b1;
    tests_run++;
    if (dut.state !== FLUSH) begin
      tests_failed++;
      $display("FAIL flush_state: got %0d expected %0d", dut.state, FLUSH);
    end
    for (int i = 0; i < 14; i++) step(1'b0, 32'h0);
    tests_run++;
    if (first_xfer_pc !== 32'h0000_0100 || track_first) begin
      tests_failed++;
      $display("FAIL flush_first_pc: got %h expected 00000100", first_xfer_pc);
    end
    lat = 1;
    drain("flush");
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0202);
    tests_run++;
    if (FetchMisaligned !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_pulse: got %b expected 1", FetchMisaligned);
    end
    step(1'b0, 32'h0);
    tests_run++;
    if (FetchMisaligned !== 1'b0) begin
      tests_failed++;
      $display("FAIL misaligned_width: got %b expected 0", FetchMisaligned);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    drain("misaligned");
  endtask

  task automatic test_redirect_rsp();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (arrived > 0 && mem_rdy_q.size() > 0 && mem_rdy_q[0] <= cyc) found = 1'b1;
      else step(1'b0, 32'h0);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL redir_rsp_setup: got arrived=%0d expected a valid entry and a response", arrived);
    end
    step(1'b1, 32'h0000_0040);
    tests_run++;
    if (FetchValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_rsp_empty: got fv=%b expected 0", FetchValid);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    drain("redir_rsp");
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
    tests_run++;
    if (exp_pc[31:16] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap: got next pc %h expected wrapped to low addresses", exp_pc);
    end
    drain("wrap");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
    apply_reset(2);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    drain("mid_reset");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_misaligned();
    test_redirect_rsp();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
